// File: rtl/pad_frame_pkg.sv
// Shared geometry and state encoding for the padded frame buffer.
// The window reader imports the same constants.
package pad_frame_pkg;

    localparam int PW     = 8;
    localparam int IMG_W  = 256;
    localparam int IMG_H  = 32;
    localparam int ADDR_W = 14;
    localparam int COL_W  = 9;
    localparam int ROW_W  = 6;

    localparam int PAD_W     = IMG_W + 2;
    localparam int MEM_DEPTH = PAD_W * (IMG_H + 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_TOP    = 3'd1;
    localparam logic [2:0] ST_LEFT   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_RIGHT  = 3'd4;
    localparam logic [2:0] ST_BOTTOM = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;

endpackage

// File: rtl/pad_pos_counter.sv
// Column/row position within the padded frame, with end-of-run flags
// that the writer FSM uses to leave each border or data segment.
module pad_pos_counter
    import pad_frame_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic col_step,
    input  logic col_clear,
    input  logic row_step,
    input  logic row_load,
    output logic last_pad_col,
    output logic last_img_col,
    output logic last_row
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else begin
            if (col_clear)
                col <= '0;
            else if (col_step)
                col <= col + 1'b1;

            if (row_load)
                row <= ROW_W'(1);
            else if (row_step)
                row <= row + 1'b1;
        end
    end

    assign last_pad_col = (col == COL_W'(PAD_W - 1));
    assign last_img_col = (col == COL_W'(IMG_W - 1));
    assign last_row     = (row == ROW_W'(IMG_H));

endmodule

// File: rtl/pad_frame_writer.sv
// Writes a zero-bordered (IMG_W+2) x (IMG_H+2) frame into image memory from a
// raster pixel stream, one sequential address per write.
module pad_frame_writer
    import pad_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PW-1:0]     pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PW-1:0]     mem_data,
    output logic              busy,
    output logic              done
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [2:0]        eff_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en;
    logic [PW-1:0]     wr_data;
    logic              col_step;
    logic              col_clear;
    logic              row_step;
    logic              row_load;
    logic              last_pad_col;
    logic              last_img_col;
    logic              last_row;

    pad_pos_counter u_pos (
        .clk          (clk),
        .rst          (rst),
        .col_step     (col_step),
        .col_clear    (col_clear),
        .row_step     (row_step),
        .row_load     (row_load),
        .last_pad_col (last_pad_col),
        .last_img_col (last_img_col),
        .last_row     (last_row)
    );

    // The start edge already issues the first top-border write, so address 0
    // appears in the cycle right after start.
    assign eff_state = (state == ST_IDLE && start) ? ST_TOP : state;
    assign pix_ready = (state == ST_DATA);

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = eff_state;
        wr_en     = 1'b0;
        wr_data   = '0;
        col_step  = 1'b0;
        col_clear = 1'b0;
        row_step  = 1'b0;
        row_load  = 1'b0;
        case (eff_state)
            ST_TOP, ST_BOTTOM: begin
                wr_en = 1'b1;
                if (last_pad_col) begin
                    col_clear = 1'b1;
                    if (eff_state == ST_TOP) begin
                        row_load  = 1'b1;
                        state_nxt = ST_LEFT;
                    end else begin
                        state_nxt = ST_FIN;
                    end
                end else begin
                    col_step = 1'b1;
                end
            end
            ST_LEFT: begin
                wr_en     = 1'b1;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (pix_valid) begin
                    wr_en   = 1'b1;
                    wr_data = pix_in;
                    if (last_img_col) begin
                        col_clear = 1'b1;
                        state_nxt = ST_RIGHT;
                    end else begin
                        col_step = 1'b1;
                    end
                end
            end
            ST_RIGHT: begin
                wr_en = 1'b1;
                if (last_row) begin
                    state_nxt = ST_BOTTOM;
                end else begin
                    row_step  = 1'b1;
                    state_nxt = ST_LEFT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state  <= state_nxt;
            mem_wr <= wr_en;
            done   <= (state == ST_FIN);
            busy   <= (eff_state != ST_IDLE) && (eff_state != ST_FIN);
            if (wr_en) begin
                mem_addr <= wr_ptr;
                mem_data <= wr_data;
                wr_ptr   <= wr_ptr + 1'b1;
            end else if (state == ST_FIN) begin
                wr_ptr <= '0;
            end
        end
    end

endmodule
